// File: rtl/mips_pkg.sv
// Shared constants and types for the 16-bit MIPS pipeline: opcodes, funct codes,
// register-file geometry and the ID/EX bundle layout.
package mips_pkg;

    localparam int REG_W    = 16;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;
    localparam int ALU_OP_W = 3;

    localparam logic [REG_W-1:0] NOP = 16'h0000;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b1111;

    localparam logic [ALU_OP_W-1:0] FN_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] FN_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] FN_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] FN_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] FN_SLT = 3'b100;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] npc;
        logic [REG_W-1:0] ins;
    } if_id_t;

    typedef struct packed {
        logic                valid;
        logic [REG_W-1:0]    npc;
        logic [REG_W-1:0]    rs_val;
        logic [REG_W-1:0]    rt_val;
        logic [REG_W-1:0]    imm;
        logic [REG_AW-1:0]   dst;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                mem_rd;
        logic                mem_wr;
        logic                reg_wr;
    } id_ex_t;

    function automatic logic [REG_W-1:0] sext6(input logic [5:0] imm);
        return {{(REG_W-6){imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 8x16 register file: two combinational read ports with write-first bypass,
// one synchronous write port; r0 is hard-wired to zero.
module reg_file
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [REG_W-1:0]  rd_data_a,
    output logic [REG_W-1:0]  rd_data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [REG_W-1:0]  wr_data
);

    logic [REG_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr != '0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // A write landing this cycle is forwarded so ID sees the newest value.
    function automatic logic [REG_W-1:0] read_port(input logic [REG_AW-1:0] addr,
                                                   input logic [REG_W-1:0]  stored);
        if (addr == '0) begin
            return '0;
        end else if (wr_en && (wr_addr == addr)) begin
            return wr_data;
        end else begin
            return stored;
        end
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a, mem_q[rd_addr_a]);
        rd_data_b = read_port(rd_addr_b, mem_q[rd_addr_b]);
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, register-file read, control decode,
// BEQ/BNE resolution with fetch redirect, and the registered ID/EX bundle.
module id_stage
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_W-1:0]    NPC_IF,
    input  logic [REG_W-1:0]    INS_IF,
    input  logic                wb_en,
    input  logic [REG_AW-1:0]   wb_addr,
    input  logic [REG_W-1:0]    wb_data,
    output logic                do_branch,
    output logic [REG_W-1:0]    branch_addr,
    output logic                ex_valid,
    output logic [REG_W-1:0]    ex_npc,
    output logic [REG_W-1:0]    ex_rs_val,
    output logic [REG_W-1:0]    ex_rt_val,
    output logic [REG_W-1:0]    ex_imm,
    output logic [REG_AW-1:0]   ex_dst,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_mem_rd,
    output logic                ex_mem_wr,
    output logic                ex_reg_wr
);

    if_id_t if_id_q, if_id_d;
    id_ex_t id_ex_q, id_ex_d;

    logic [3:0]          opcode;
    logic [REG_AW-1:0]   rs, rt, rd;
    logic [ALU_OP_W-1:0] funct;
    logic [REG_W-1:0]    imm_sext;
    logic [REG_W-1:0]    rs_val, rt_val;

    assign opcode   = if_id_q.ins[15:12];
    assign rs       = if_id_q.ins[11:9];
    assign rt       = if_id_q.ins[8:6];
    assign rd       = if_id_q.ins[5:3];
    assign funct    = if_id_q.ins[2:0];
    assign imm_sext = sext6(if_id_q.ins[5:0]);

    reg_file u_reg_file (
        .clk       (clk),
        .rd_addr_a (rs),
        .rd_addr_b (rt),
        .rd_data_a (rs_val),
        .rd_data_b (rt_val),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // Branch resolves in ID using the bypassed operands, one-slot penalty.
    always_comb begin
        do_branch   = if_id_q.valid &&
                      (((opcode == OP_BEQ) && (rs_val == rt_val)) ||
                       ((opcode == OP_BNE) && (rs_val != rt_val)));
        branch_addr = if_id_q.npc + {imm_sext[REG_W-2:0], 1'b0};
    end

    always_comb begin
        if_id_d = '{valid: 1'b1, npc: NPC_IF, ins: INS_IF};
        if (do_branch) begin
            if_id_d = '{valid: 1'b0, npc: '0, ins: NOP};
        end
    end

    always_comb begin
        id_ex_d        = '0;
        id_ex_d.valid  = if_id_q.valid;
        id_ex_d.npc    = if_id_q.npc;
        id_ex_d.rs_val = rs_val;
        id_ex_d.rt_val = rt_val;
        id_ex_d.imm    = imm_sext;
        unique case (opcode)
            OP_RTYPE: begin
                id_ex_d.alu_op = funct;
                id_ex_d.dst    = rd;
                id_ex_d.reg_wr = (funct <= FN_SLT);
            end
            OP_ADDI, OP_LW: begin
                id_ex_d.alu_op  = FN_ADD;
                id_ex_d.alu_src = 1'b1;
                id_ex_d.dst     = rt;
                id_ex_d.reg_wr  = 1'b1;
                id_ex_d.mem_rd  = (opcode == OP_LW);
            end
            OP_SW: begin
                id_ex_d.alu_op  = FN_ADD;
                id_ex_d.alu_src = 1'b1;
                id_ex_d.mem_wr  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                id_ex_d.alu_op = FN_SUB;
            end
            default: ;
        endcase
        // A flushed or empty slot becomes a clean bubble.
        if (!if_id_q.valid) begin
            id_ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q <= '0;
            id_ex_q <= '0;
        end else begin
            if_id_q <= if_id_d;
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_valid   = id_ex_q.valid;
    assign ex_npc     = id_ex_q.npc;
    assign ex_rs_val  = id_ex_q.rs_val;
    assign ex_rt_val  = id_ex_q.rt_val;
    assign ex_imm     = id_ex_q.imm;
    assign ex_dst     = id_ex_q.dst;
    assign ex_alu_op  = id_ex_q.alu_op;
    assign ex_alu_src = id_ex_q.alu_src;
    assign ex_mem_rd  = id_ex_q.mem_rd;
    assign ex_mem_wr  = id_ex_q.mem_wr;
    assign ex_reg_wr  = id_ex_q.reg_wr;

endmodule
